// File: rtl/ping_pong_sequencer.sv
// Segment scheduler for the ping-pong counter: walks a small (min, max, bounces)
// table, counts direction reversals and drives the counter's control inputs.
module ping_pong_sequencer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 4,
  parameter int unsigned BW    = 3,
  parameter int unsigned LOOP  = 0,
  localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             count_clk,
  input  logic             filtered_rst,
  input  logic             cfg_we,
  input  logic [AW-1:0]    cfg_addr,
  input  logic [WIDTH-1:0] cfg_min,
  input  logic [WIDTH-1:0] cfg_max,
  input  logic [BW-1:0]    cfg_bounces,
  input  logic [AW-1:0]    seg_last,
  input  logic             start,
  input  logic             stop,
  input  logic             flip_req,
  input  logic             ctr_direction,
  output logic             ctr_enable,
  output logic             ctr_flip,
  output logic [WIDTH-1:0] ctr_max,
  output logic [WIDTH-1:0] ctr_min,
  output logic             ctr_rst_n,
  output logic [AW-1:0]    seg_idx,
  output logic             busy,
  output logic             done,
  output logic             error
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] tmin_q [DEPTH];
  logic [WIDTH-1:0] tmin_d [DEPTH];
  logic [WIDTH-1:0] tmax_q [DEPTH];
  logic [WIDTH-1:0] tmax_d [DEPTH];
  logic [BW-1:0]    tbnc_q [DEPTH];
  logic [BW-1:0]    tbnc_d [DEPTH];

  logic             ctr_enable_q, ctr_enable_d;
  logic             ctr_flip_q, ctr_flip_d;
  logic [WIDTH-1:0] ctr_max_q, ctr_max_d;
  logic [WIDTH-1:0] ctr_min_q, ctr_min_d;
  logic             ctr_rst_n_q, ctr_rst_n_d;
  logic [AW-1:0]    seg_idx_q, seg_idx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             error_q, error_d;
  logic [BW-1:0]    bcnt_q, bcnt_d;
  logic             prev_dir_q, prev_dir_d;
  logic             flip_mask_q, flip_mask_d;

  logic [WIDTH-1:0] cur_min, cur_max;
  logic [BW-1:0]    cur_bnc, bump;
  logic             bounce, seg_end;

  assign cur_min = tmin_q[seg_idx_q];
  assign cur_max = tmax_q[seg_idx_q];
  assign cur_bnc = tbnc_q[seg_idx_q];
  assign bump    = bcnt_q + BW'(1);
  // A reversal in the cycle after our own flip pulse is the flip, not a bounce.
  assign bounce  = (ctr_direction != prev_dir_q) && !flip_mask_q;
  assign seg_end = bounce && (cur_bnc != '0) && (bump == cur_bnc);

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    tmin_d       = tmin_q;
    tmax_d       = tmax_q;
    tbnc_d       = tbnc_q;
    ctr_enable_d = ctr_enable_q;
    ctr_flip_d   = 1'b0;
    ctr_max_d    = ctr_max_q;
    ctr_min_d    = ctr_min_q;
    ctr_rst_n_d  = ctr_rst_n_q;
    seg_idx_d    = seg_idx_q;
    busy_d       = busy_q;
    done_d       = done_q;
    error_d      = error_q;
    bcnt_d       = bcnt_q;
    prev_dir_d   = prev_dir_q;
    flip_mask_d  = ctr_flip_q;

    if (cfg_we && !busy_q) begin
      tmin_d[cfg_addr] = cfg_min;
      tmax_d[cfg_addr] = cfg_max;
      tbnc_d[cfg_addr] = cfg_bounces;
    end

    unique case (state_q)
      IDLE: begin
        ctr_enable_d = 1'b0;
        ctr_rst_n_d  = 1'b1;
        busy_d       = 1'b0;
        done_d       = 1'b0;
        if (start) begin
          state_d   = LOAD;
          seg_idx_d = '0;
          error_d   = 1'b0;
        end
      end
      LOAD: begin
        ctr_max_d    = cur_max;
        ctr_min_d    = cur_min;
        ctr_rst_n_d  = 1'b0;
        ctr_enable_d = 1'b0;
        busy_d       = 1'b1;
        done_d       = 1'b0;
        bcnt_d       = '0;
        prev_dir_d   = 1'b1;
        if (cur_min >= cur_max) begin
          error_d = 1'b1;
          state_d = DONE;
        end else begin
          state_d = RUN;
        end
      end
      RUN: begin
        ctr_enable_d = 1'b1;
        ctr_rst_n_d  = 1'b1;
        busy_d       = 1'b1;
        done_d       = 1'b0;
        prev_dir_d   = ctr_direction;
        if (bounce) bcnt_d = bump;
        if (seg_end) begin
          if (seg_idx_q < seg_last) begin
            seg_idx_d = seg_idx_q + AW'(1);
            state_d   = LOAD;
          end else if (LOOP != 0) begin
            seg_idx_d = '0;
            state_d   = LOAD;
          end else begin
            state_d = DONE;
          end
        end else if (flip_req) begin
          ctr_flip_d = 1'b1;
        end
      end
      DONE: begin
        ctr_enable_d = 1'b0;
        ctr_rst_n_d  = 1'b1;
        busy_d       = 1'b0;
        done_d       = 1'b1;
        if (start) begin
          state_d   = LOAD;
          seg_idx_d = '0;
          error_d   = 1'b0;
          done_d    = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    // Stop overrides start, segment advance and any pending flip.
    if (stop) begin
      state_d      = IDLE;
      seg_idx_d    = '0;
      ctr_enable_d = 1'b0;
      ctr_flip_d   = 1'b0;
      ctr_rst_n_d  = 1'b1;
      busy_d       = 1'b0;
      done_d       = 1'b0;
    end
  end

  always_ff @(posedge count_clk or posedge filtered_rst) begin
    if (filtered_rst) begin
      state_q <= IDLE;
      for (int i = 0; i < int'(DEPTH); i++) begin
        tmin_q[i] <= '0;
        tmax_q[i] <= '1;
        tbnc_q[i] <= '0;
      end
      ctr_enable_q <= 1'b0;
      ctr_flip_q   <= 1'b0;
      ctr_max_q    <= '1;
      ctr_min_q    <= '0;
      ctr_rst_n_q  <= 1'b0;
      seg_idx_q    <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      bcnt_q       <= '0;
      prev_dir_q   <= 1'b1;
      flip_mask_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      tmin_q       <= tmin_d;
      tmax_q       <= tmax_d;
      tbnc_q       <= tbnc_d;
      ctr_enable_q <= ctr_enable_d;
      ctr_flip_q   <= ctr_flip_d;
      ctr_max_q    <= ctr_max_d;
      ctr_min_q    <= ctr_min_d;
      ctr_rst_n_q  <= ctr_rst_n_d;
      seg_idx_q    <= seg_idx_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
      bcnt_q       <= bcnt_d;
      prev_dir_q   <= prev_dir_d;
      flip_mask_q  <= flip_mask_d;
    end
  end

  assign ctr_enable = ctr_enable_q;
  assign ctr_flip   = ctr_flip_q;
  assign ctr_max    = ctr_max_q;
  assign ctr_min    = ctr_min_q;
  assign ctr_rst_n  = ctr_rst_n_q;
  assign seg_idx    = seg_idx_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;

endmodule

// File: tb/tb_ping_pong_sequencer.sv
// Scoreboard bench for ping_pong_sequencer: a LOOP=0 and a LOOP=1 instance share
// stimulus; expectations are queued per cycle and checked by a separate monitor.
module tb_ping_pong_sequencer;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned BW    = 3;
  localparam int unsigned AW    = 2;
  localparam int L = 16;
  localparam int S_EN = 0, S_FLIP = 1, S_MAX = 2, S_MIN = 3, S_RSTN = 4;
  localparam int S_IDX = 5, S_BUSY = 6, S_DONE = 7, S_ERR = 8;

  logic             count_clk;
  logic             filtered_rst;
  logic             cfg_we;
  logic [AW-1:0]    cfg_addr;
  logic [WIDTH-1:0] cfg_min, cfg_max;
  logic [BW-1:0]    cfg_bounces;
  logic [AW-1:0]    seg_last;
  logic             start, stop, flip_req, ctr_direction;

  logic             ctr_enable, ctr_flip, ctr_rst_n, busy, done, error;
  logic [WIDTH-1:0] ctr_max, ctr_min;
  logic [AW-1:0]    seg_idx;
  logic             l_ctr_enable, l_ctr_flip, l_ctr_rst_n, l_busy, l_done, l_error;
  logic [WIDTH-1:0] l_ctr_max, l_ctr_min;
  logic [AW-1:0]    l_seg_idx;

  ping_pong_sequencer #(.DEPTH(4), .WIDTH(WIDTH), .BW(BW), .LOOP(0)) u_dut (
    .count_clk(count_clk), .filtered_rst(filtered_rst), .cfg_we(cfg_we),
    .cfg_addr(cfg_addr), .cfg_min(cfg_min), .cfg_max(cfg_max),
    .cfg_bounces(cfg_bounces), .seg_last(seg_last), .start(start), .stop(stop),
    .flip_req(flip_req), .ctr_direction(ctr_direction), .ctr_enable(ctr_enable),
    .ctr_flip(ctr_flip), .ctr_max(ctr_max), .ctr_min(ctr_min),
    .ctr_rst_n(ctr_rst_n), .seg_idx(seg_idx), .busy(busy), .done(done),
    .error(error));

  ping_pong_sequencer #(.DEPTH(4), .WIDTH(WIDTH), .BW(BW), .LOOP(1)) u_loop (
    .count_clk(count_clk), .filtered_rst(filtered_rst), .cfg_we(cfg_we),
    .cfg_addr(cfg_addr), .cfg_min(cfg_min), .cfg_max(cfg_max),
    .cfg_bounces(cfg_bounces), .seg_last(seg_last), .start(start), .stop(stop),
    .flip_req(flip_req), .ctr_direction(ctr_direction), .ctr_enable(l_ctr_enable),
    .ctr_flip(l_ctr_flip), .ctr_max(l_ctr_max), .ctr_min(l_ctr_min),
    .ctr_rst_n(l_ctr_rst_n), .seg_idx(l_seg_idx), .busy(l_busy), .done(l_done),
    .error(l_error));

  typedef struct {
    int unsigned cyc;
    int          sel;
    int unsigned val;
    string       name;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  initial count_clk = 1'b0;
  always #5 count_clk = ~count_clk;
  always @(posedge count_clk) cyc <= cyc + 1;

  function automatic int unsigned probe(input int sel);
    case (sel)
      S_EN:       return 32'(ctr_enable);
      S_FLIP:     return 32'(ctr_flip);
      S_MAX:      return 32'(ctr_max);
      S_MIN:      return 32'(ctr_min);
      S_RSTN:     return 32'(ctr_rst_n);
      S_IDX:      return 32'(seg_idx);
      S_BUSY:     return 32'(busy);
      S_DONE:     return 32'(done);
      S_ERR:      return 32'(error);
      L + S_EN:   return 32'(l_ctr_enable);
      L + S_FLIP: return 32'(l_ctr_flip);
      L + S_MAX:  return 32'(l_ctr_max);
      L + S_MIN:  return 32'(l_ctr_min);
      L + S_RSTN: return 32'(l_ctr_rst_n);
      L + S_IDX:  return 32'(l_seg_idx);
      L + S_BUSY: return 32'(l_busy);
      L + S_DONE: return 32'(l_done);
      L + S_ERR:  return 32'(l_error);
      default:    return 32'hDEAD_BEEF;
    endcase
  endfunction

  function automatic void chk(input string nm, input int unsigned act, input int unsigned exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  task automatic ex(input int unsigned dc, input int sel, input int unsigned val, input string nm);
    exp_t e;
    e.cyc  = cyc + dc;
    e.sel  = sel;
    e.val  = val;
    e.name = nm;
    sb.push_back(e);
  endtask

  task automatic nb(input int n);
    repeat (n) @(negedge count_clk);
  endtask

  // Monitor: compares every queued expectation that falls due this cycle.
  always @(negedge count_clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc <= cyc) begin
        chk(sb[i].name, probe(sb[i].sel), sb[i].val);
        sb.delete(i);
      end
    end
  end

  initial begin
    filtered_rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_min = '0; cfg_max = '0;
    cfg_bounces = '0; seg_last = '0; start = 1'b0; stop = 1'b0; flip_req = 1'b0;
    ctr_direction = 1'b1;
    nb(1);
    ex(1, S_RSTN, 0, "rst_ctr_rst_n"); ex(1, S_MAX, 15, "rst_ctr_max");
    ex(1, S_MIN, 0, "rst_ctr_min");    ex(1, S_EN, 0, "rst_ctr_enable");
    ex(1, S_BUSY, 0, "rst_busy");      ex(1, S_DONE, 0, "rst_done");
    ex(1, S_ERR, 0, "rst_error");      ex(1, S_IDX, 0, "rst_seg_idx");
    ex(1, S_FLIP, 0, "rst_ctr_flip");
    nb(1); filtered_rst = 1'b0;
    nb(2);

    flip_req = 1'b1;
    ex(1, S_FLIP, 0, "idle_flip_ignored"); ex(2, S_FLIP, 0, "idle_flip_ignored2");
    ex(1, S_RSTN, 1, "idle_rst_n");
    nb(1); flip_req = 1'b0; nb(1);

    // Default table: segment 0..15, bounces 0 runs until stop.
    start = 1'b1;
    ex(2, S_RSTN, 0, "load_rst_n"); ex(2, S_MIN, 0, "load_min"); ex(2, S_MAX, 15, "load_max");
    ex(2, S_EN, 0, "load_enable");  ex(2, S_BUSY, 1, "load_busy");
    ex(3, S_EN, 1, "run_enable");   ex(3, S_RSTN, 1, "run_rst_n");
    ex(203, S_BUSY, 1, "unbounded_busy"); ex(203, S_EN, 1, "unbounded_enable");
    ex(203, L + S_BUSY, 1, "loop_unbounded_busy");
    nb(1); start = 1'b0;
    nb(204);
    stop = 1'b1;
    ex(1, S_EN, 0, "stop_enable"); ex(1, S_BUSY, 0, "stop_busy"); ex(1, L + S_EN, 0, "loop_stop_enable");
    nb(1); stop = 1'b0; nb(1);

    // Program entry0 (2,5,2), entry1 (7,9,1), seg_last=1.
    cfg_we = 1'b1; cfg_addr = 2'd0; cfg_min = 4'd2; cfg_max = 4'd5; cfg_bounces = 3'd2; nb(1);
    cfg_addr = 2'd1; cfg_min = 4'd7; cfg_max = 4'd9; cfg_bounces = 3'd1; nb(1);
    cfg_we = 1'b0; seg_last = 2'd1; nb(1);
    start = 1'b1;
    ex(2, S_MIN, 2, "seg0_min"); ex(2, S_MAX, 5, "seg0_max"); ex(3, S_EN, 1, "seg0_enable");
    nb(1); start = 1'b0; nb(2);
    ctr_direction = 1'b0; nb(2);
    ctr_direction = 1'b1;
    ex(2, S_IDX, 1, "seg1_idx"); ex(2, S_MIN, 7, "seg1_min"); ex(2, S_MAX, 9, "seg1_max");
    ex(2, L + S_IDX, 1, "loop_seg1_idx");
    nb(3);
    ctr_direction = 1'b0;
    ex(2, S_DONE, 1, "last_done"); ex(2, S_EN, 0, "last_enable"); ex(2, S_BUSY, 0, "last_busy");
    ex(2, S_MAX, 9, "done_hold_max");
    ex(2, L + S_IDX, 0, "loop_wrap_idx"); ex(2, L + S_MIN, 2, "loop_wrap_min");
    ex(2, L + S_MAX, 5, "loop_wrap_max"); ex(2, L + S_BUSY, 1, "loop_wrap_busy");
    nb(2);
    stop = 1'b1; start = 1'b1;
    ex(1, S_DONE, 0, "stopstart_done"); ex(1, S_BUSY, 0, "stopstart_busy");
    ex(1, L + S_BUSY, 0, "loop_stopstart_busy"); ex(1, L + S_EN, 0, "loop_stopstart_enable");
    ex(3, L + S_BUSY, 0, "loop_stop_wins_busy"); ex(3, L + S_RSTN, 1, "loop_stop_wins_rst_n");
    ex(3, S_BUSY, 0, "stop_wins_busy");
    nb(1); stop = 1'b0; start = 1'b0; nb(2);

    // User flip: the reversal it causes must not count toward entry0's 2 bounces.
    ctr_direction = 1'b1; nb(1);
    start = 1'b1; nb(1); start = 1'b0; nb(2);
    flip_req = 1'b1;
    ex(1, S_FLIP, 1, "flip_pulse"); ex(2, S_FLIP, 0, "flip_one_cycle");
    ex(1, L + S_FLIP, 1, "loop_flip_pulse");
    nb(1); flip_req = 1'b0; nb(1);
    ctr_direction = 1'b0; nb(1);
    ctr_direction = 1'b1;
    ex(1, S_IDX, 0, "flip_not_counted"); ex(2, S_IDX, 1, "flip_then_advance");
    nb(1);
    ctr_direction = 1'b0; nb(2);
    stop = 1'b1; nb(1); stop = 1'b0; nb(1);

    // Invalid entry min == max.
    cfg_we = 1'b1; cfg_addr = 2'd0; cfg_min = 4'd6; cfg_max = 4'd6; cfg_bounces = 3'd1;
    seg_last = 2'd0; nb(1); cfg_we = 1'b0; nb(1);
    start = 1'b1;
    ex(2, S_ERR, 1, "bad_error"); ex(2, S_EN, 0, "bad_enable_load");
    ex(3, S_DONE, 1, "bad_done"); ex(3, S_EN, 0, "bad_enable_done"); ex(3, S_BUSY, 0, "bad_busy");
    ex(5, S_EN, 0, "bad_enable_later"); ex(3, L + S_ERR, 1, "loop_bad_error");
    nb(1); start = 1'b0; nb(2);
    flip_req = 1'b1; ex(1, S_FLIP, 0, "done_flip_ignored");
    nb(1); flip_req = 1'b0; nb(2);

    // Write together with start lands first; a later write while busy is dropped.
    cfg_we = 1'b1; cfg_addr = 2'd0; cfg_min = 4'd2; cfg_max = 4'd5; cfg_bounces = 3'd0; start = 1'b1;
    ex(1, S_ERR, 0, "restart_error_clr"); ex(1, S_DONE, 0, "restart_done_clr");
    ex(2, S_MIN, 2, "wrstart_min"); ex(2, S_MAX, 5, "wrstart_max"); ex(2, S_BUSY, 1, "wrstart_busy");
    ex(3, S_EN, 1, "wrstart_enable");
    nb(1); cfg_we = 1'b0; start = 1'b0; nb(2);
    cfg_we = 1'b1; cfg_min = 4'd1; cfg_max = 4'd3; cfg_bounces = 3'd1;
    nb(1); cfg_we = 1'b0;
    nb(1); stop = 1'b1; nb(1); stop = 1'b0; nb(1);
    start = 1'b1;
    ex(2, S_MIN, 2, "busy_write_dropped_min"); ex(2, S_MAX, 5, "busy_write_dropped_max");
    ex(3, S_EN, 1, "busy_write_run_enable");
    nb(1); start = 1'b0; nb(3);

    // Asynchronous reset in the middle of RUN.
    #2 filtered_rst = 1'b1;
    #1;
    chk("async_rst_enable", probe(S_EN), 0);
    chk("async_rst_rst_n", probe(S_RSTN), 0);
    chk("async_rst_max", probe(S_MAX), 15);
    chk("async_rst_min", probe(S_MIN), 0);
    chk("async_rst_busy", probe(S_BUSY), 0);
    chk("loop_async_rst_busy", probe(L + S_BUSY), 0);
    nb(1); filtered_rst = 1'b0; nb(2);
    start = 1'b1;
    ex(2, S_MIN, 0, "table_cleared_min"); ex(2, S_MAX, 15, "table_cleared_max");
    nb(1); start = 1'b0; nb(5);

    foreach (sb[i]) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: expectation never checked (due cycle %0d)", sb[i].name, sb[i].cyc);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
